// File: rtl/key_expand_inv.sv
// Iterative AES-128 inverse key scheduler: takes round key ROUNDS and streams
// round keys ROUNDS..0 in descending order, one every two cycles.
module key_expand_inv #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last
);

  localparam logic [3:0] ROUNDS_W = 4'(ROUNDS);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EMIT, SUB} state_t;

  state_t       state;
  logic [127:0] key_reg;
  logic [3:0]   rcnt;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return SBOX[(255 - idx) * 8 +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_key   = key_reg;
  assign out_round = rcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      key_reg   <= '0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key_reg   <= key_in;
            rcnt      <= ROUNDS_W;
            out_valid <= 1'b1;
            out_last  <= (ROUNDS_W == 4'd0);
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (rcnt == 4'd0) begin
              state <= IDLE;
            end else begin
              // Words 1..3 of the previous key fall out of the XOR chain directly.
              key_reg <= {key_reg[127:96],
                          key_reg[95:64] ^ key_reg[127:96],
                          key_reg[63:32] ^ key_reg[95:64],
                          key_reg[31:0]  ^ key_reg[63:32]};
              state   <= SUB;
            end
          end
        end
        SUB: begin
          // Word 0 needs the recovered word 3, now sitting in key_reg[31:0].
          key_reg[127:96] <= key_reg[127:96]
                             ^ sub_word({key_reg[23:0], key_reg[31:24]})
                             ^ rcon(rcnt - 4'd1);
          rcnt      <= rcnt - 4'd1;
          out_valid <= 1'b1;
          out_last  <= (rcnt == 4'd1);
          state     <= EMIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand_inv.sv
// Directed bench for key_expand_inv: FIPS-197 vector, backpressure, busy input,
// reset abort, ROUNDS=1 build and random keys against a forward expansion model.
module tb_key_expand_inv;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_last;

  logic         in_valid1 = 1'b0;
  logic         in_ready1;
  logic [127:0] key_in1 = '0;
  logic         out_valid1;
  logic         out_ready1 = 1'b0;
  logic [127:0] out_key1;
  logic [3:0]   out_round1;
  logic         out_last1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbox [256];
  logic [7:0]   rc   [10];
  logic [127:0] rk   [11];
  logic [127:0] got  [11];

  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] OTHER    = 128'h00112233445566778899aabbccddeeff;

  key_expand_inv #(.ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key_in(key_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
    .out_round(out_round), .out_last(out_last)
  );

  key_expand_inv #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .key_in(key_in1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_key(out_key1),
    .out_round(out_round1), .out_last(out_last1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc[0] = 8'h01;
    for (int i = 1; i < 10; i++) rc[i] = xtime(rc[i-1]);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // Forward AES-128 expansion of a round 0 key into rk[0..10].
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Feed rk[10] and consume all 11 keys; optional random backpressure and busy in_valid.
  task automatic run_seq(input bit bp, input bit busy);
    int idx;
    int cyc;
    bit held;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("idle_ready", 128'(in_ready), 128'(1));
    in_valid  = 1'b1;
    key_in    = rk[10];
    out_ready = 1'b1;
    @(posedge clk); #1;
    if (busy) key_in = OTHER;
    else in_valid = 1'b0;
    idx  = 10;
    cyc  = 1;
    held = 1'b0;
    while (idx >= 0 && cyc < 400) begin
      out_ready = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (held) check("hold_valid", 128'(out_valid), 128'(1));
      if (busy) check("busy_ready", 128'(in_ready), 128'(0));
      if (out_valid) begin
        check("key", out_key, rk[idx]);
        check("round", 128'(out_round), 128'(idx));
        check("last", 128'(out_last), 128'(idx == 0));
        if (!bp) check("cycle", 128'(cyc), 128'(1 + 2*(10 - idx)));
        held = !out_ready;
        if (out_ready) begin
          got[idx] = out_key;
          idx--;
        end
      end else begin
        held = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("seq_done", 128'(idx < 0), 128'(1));
    check("post_ready", 128'(in_ready), 128'(1));
    check("post_valid", 128'(out_valid), 128'(0));
    if (busy) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("busy_accept_valid", 128'(out_valid), 128'(1));
      check("busy_accept_key", out_key, OTHER);
      check("busy_accept_round", 128'(out_round), 128'(10));
    end
  endtask

  initial begin
    int cyc;
    build_tables();

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_key", out_key, 128'(0));
    check("rst_round", 128'(out_round), 128'(0));
    check("rst_last", 128'(out_last), 128'(0));
    check("rst_ready", 128'(in_ready), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_valid", 128'(out_valid), 128'(0));
    check("idle_ready1", 128'(in_ready1), 128'(1));

    expand(FIPS_R0);
    run_seq(1'b0, 1'b0);
    check("fips_r10", got[10], FIPS_R10);
    check("fips_r9", got[9], FIPS_R9);
    check("fips_r1", got[1], FIPS_R1);
    check("fips_r0", got[0], FIPS_R0);

    run_seq(1'b1, 1'b0);
    run_seq(1'b0, 1'b1);

    // Clear the busy-accepted sequence, then abort a FIPS run after round 6.
    rst = 1'b0;
    #1 rst = 1'b1;
    in_valid  = 1'b1;
    key_in    = FIPS_R10;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!(out_valid && out_round == 4'd5) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach", 128'(out_valid && out_round == 4'd5), 128'(1));
    #2 rst = 1'b0;
    #1;
    check("abort_valid", 128'(out_valid), 128'(0));
    check("abort_ready", 128'(in_ready), 128'(1));
    check("abort_round", 128'(out_round), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_quiet", 128'(out_valid), 128'(0));
    run_seq(1'b0, 1'b0);

    in_valid1  = 1'b1;
    key_in1    = FIPS_R1;
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("r1_valid_a", 128'(out_valid1), 128'(1));
    check("r1_key_a", out_key1, FIPS_R1);
    check("r1_round_a", 128'(out_round1), 128'(1));
    check("r1_last_a", 128'(out_last1), 128'(0));
    @(posedge clk); #1;
    check("r1_gap", 128'(out_valid1), 128'(0));
    @(posedge clk); #1;
    check("r1_valid_b", 128'(out_valid1), 128'(1));
    check("r1_key_b", out_key1, FIPS_R0);
    check("r1_round_b", 128'(out_round1), 128'(0));
    check("r1_last_b", 128'(out_last1), 128'(1));
    @(posedge clk); #1;
    check("r1_done_valid", 128'(out_valid1), 128'(0));
    check("r1_done_ready", 128'(in_ready1), 128'(1));

    for (int n = 0; n < 1000; n++) begin
      expand({$urandom(), $urandom(), $urandom(), $urandom()});
      run_seq(1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expand_inv.md
# key_expand_inv

Iterative AES-128 inverse key scheduler for the decryption datapath. It accepts the final round key (round key ROUNDS) and emits every round key in descending order, ROUNDS down to 0, over a valid/ready stream. Each key is derived from the previous one by inverting the forward expansion. It feeds the inverse-cipher round pipeline, so decryption can start from the last round key without storing the full schedule.

## Interface
Parameters:
- ROUNDS, 10, index of the key presented on key_in; legal 1..10.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  key_in holds a valid final round key.
- in_ready  out  1  block can accept a key; high only in IDLE.
- key_in  in  128  round key ROUNDS; word w0 = [127:96] … w3 = [31:0].
- out_valid  out  1  out_key / out_round / out_last are valid.
- out_ready  in  1  consumer accepts the current output.
- out_key  out  128  round key, same word order as key_in.
- out_round  out  4  round index of out_key.
- out_last  out  1  high when out_round == 0.

## Operation
- FSM states: IDLE, EMIT, SUB.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: key_reg <= key_in, rcnt <= ROUNDS, go to EMIT.
- EMIT:
  - out_valid = 1; out_key = key_reg; out_round = rcnt; out_last = (rcnt == 0).
  - Outputs hold stable until out_ready.
  - On out_ready with rcnt == 0: go to IDLE.
  - On out_ready with rcnt != 0: key_reg <= {w0, w1^w0, w2^w1, w3^w2}, go to SUB.
- SUB:
  - Let p3 = key_reg[31:0].
  - key_reg[127:96] <= key_reg[127:96] ^ SubWord(RotWord(p3)) ^ rcon(rcnt-1).
  - rcnt <= rcnt - 1; go to EMIT.
- RotWord({a,b,c,d}) = {b,c,d,a}.
- SubWord applies the AES forward S-box to each byte. The S-box is an internal combinational 256-entry lookup (no sbox instance), so SUB completes in one cycle.
- rcon(i): {rc_i, 24'h0} with rc = 01,02,04,08,10,20,40,80,1b,36 for i = 0..9. This matches the forward expansion indexing: key r is built with rcon(r-1).
- in_valid outside IDLE is ignored; key_in is sampled only on the handshake.
- out_valid is low in IDLE and SUB; out_key, out_round and out_last are don't-care when out_valid = 0, but registered.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE, key_reg = 0, rcnt = 0.
  - out_valid = 0, out_key = 0, out_round = 0, out_last = 0, in_ready = 1 (combinational from state).
- Reset mid-sequence: aborts immediately. No further outputs; a new key is required.
- Latency: out_valid rises in the cycle after the input handshake, carrying key ROUNDS.
- Throughput: one key per 2 cycles with out_ready held high.
  - ROUNDS = 10: keys appear at cycles 1,3,…,21 after the handshake; 11 keys total.
- Backpressure: out_ready low holds EMIT indefinitely with all outputs unchanged.
- After the out_last handshake: IDLE, so in_ready = 1 in the next cycle. There is no overlap; a new in_valid is accepted only from IDLE.
- A simultaneous in_valid during EMIT or SUB has no effect.

## Test plan
- FIPS-197 A.1 vector:
  - Stimulus: key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, out_ready = 1.
  - Required: 11 outputs at 2-cycle spacing:
    - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
    - round 9 = ac7766f319fadc2128d12941575c006e
    - round 1 = a0fafe1788542cb123a339392a6c7605
    - round 0 = 2b7e151628aed2a6abf7158809cf4f3c, out_last = 1
- Random backpressure (out_ready toggled pseudo-randomly):
  - Same 11 keys in order, no drops or duplicates.
  - Outputs stable while out_valid & !out_ready.
- Reset:
  - After reset: out_valid = 0, out_round = 0, out_last = 0, out_key = 0, in_ready = 1.
  - Assert rst after the round 6 key is emitted: out_valid drops immediately, in_ready = 1.
  - New FIPS key afterwards: full correct 11-key sequence.
- Busy input: pulse in_valid with a different key during EMIT/SUB.
  - in_ready = 0 and the sequence is unaffected.
  - Key accepted only in the cycle after the round 0 handshake.
- Random keys (≥1000): compare every output against a reference forward expansion of the emitted round 0 key.
- ROUNDS = 1 build with key_in = a0fafe1788542cb123a339392a6c7605:
  - Outputs: round 1 (same key), then round 0 = 2b7e151628aed2a6abf7158809cf4f3c with out_last = 1.
